// File: rtl/uart_rx_stream.sv
// ============================================================================
// Module   : uart_rx_stream
// Brief    : Oversampling 8N1 UART receiver feeding a one-entry valid/ready
//            byte stream; flags framing errors and overruns.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_stream #(
   parameter int CLKS_PER_BIT = 868,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_busy
);

   localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_rx_s;
   state_t                 r_state;
   logic [c_CNT_W-1:0]     r_cnt;
   logic [2:0]             r_idx;
   logic [7:0]             r_shreg;
   logic [7:0]             r_data;
   logic                   r_valid;
   logic                   r_frame_err;
   logic                   r_overrun;
   logic                   r_busy;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
      end
   end

   assign w_rx_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_idx       <= 3'd0;
         r_shreg     <= 8'd0;
         r_data      <= 8'd0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         // A pop is scheduled first so that a same-cycle push overrides it.
         if (r_valid && i_ready) begin
            r_valid <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (!w_rx_s) begin
                  r_state <= S_START;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            S_START: begin
               if (r_cnt == c_CNT_HALF) begin
                  if (!w_rx_s) begin
                     r_state <= S_DATA;
                     r_cnt   <= '0;
                     r_idx   <= 3'd0;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + c_CNT_W'(1);
               end
            end
            S_DATA: begin
               if (r_cnt == c_CNT_FULL) begin
                  r_shreg <= {w_rx_s, r_shreg[7:1]};
                  r_cnt   <= '0;
                  r_idx   <= r_idx + 3'd1;
                  if (r_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end
               end else begin
                  r_cnt <= r_cnt + c_CNT_W'(1);
               end
            end
            S_STOP: begin
               if (r_cnt == c_CNT_FULL) begin
                  r_cnt <= '0;
                  if (w_rx_s) begin
                     if (!r_valid || i_ready) begin
                        r_data  <= r_shreg;
                        r_valid <= 1'b1;
                     end else begin
                        r_overrun <= 1'b1;
                     end
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= S_BREAK;
                  end
               end else begin
                  r_cnt <= r_cnt + c_CNT_W'(1);
               end
            end
            S_BREAK: begin
               if (w_rx_s) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_frame_err = r_frame_err;
   assign o_overrun   = r_overrun;
   assign o_busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_stream.sv
// ============================================================================
// Module   : tb_uart_rx_stream
// Brief    : Scoreboard bench for uart_rx_stream: frame-level model queues
//            expected bytes and flag counts, a monitor checks the stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_stream;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_rx = 1'b1;
   logic       i_ready = 1'b1;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_frame_err;
   logic       o_overrun;
   logic       o_busy;

   int total = 0;
   int bad = 0;

   logic [7:0] exp_q[$];
   int  exp_fe = 0, exp_ovr = 0, seen_fe = 0, seen_ovr = 0;
   bit  stall_mode = 0, m_full = 0, rand_phase = 0;

   uart_rx_stream #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .i_rx(i_rx), .o_data(o_data), .o_valid(o_valid),
      .i_ready(i_ready), .o_frame_err(o_frame_err), .o_overrun(o_overrun), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      i_rx = b;
      repeat (CPB) tick();
   endtask

   // Frame-level model: a good frame becomes a byte unless the stalled holding slot is full.
   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      if (!stop_ok) exp_fe++;
      else if (m_full) exp_ovr++;
      else begin
         exp_q.push_back(b);
         if (stall_mode) m_full = 1;
      end
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_ok);
   endtask

   task automatic drain_and_count(input string name);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
      chk({name, "_drain"}, exp_q.size(), 0);
      chk({name, "_fe_cnt"}, seen_fe, exp_fe);
      chk({name, "_ovr_cnt"}, seen_ovr, exp_ovr);
   endtask

   // Monitor: pops the scoreboard on each handshake and watches the flag pulses.
   bit         prev_hold = 0;
   logic [7:0] prev_data;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold = 0;
      end else begin
         if (prev_hold && o_valid) chk("data_stable", o_data, prev_data);
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, o_data}, 32'hFFFF_FFFF);
            else chk("byte", o_data, exp_q.pop_front());
         end
         if (o_frame_err && o_overrun) chk("flags_exclusive", 1, 0);
         if (o_frame_err) seen_fe++;
         if (o_overrun) seen_ovr++;
         prev_hold = o_valid && !i_ready;
         prev_data = o_data;
      end
   end

   initial begin
      forever begin
         tick();
         if (rand_phase) i_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      logic [7:0] rb;
      logic       ok;
      repeat (3) tick();
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_fe", o_frame_err, 0);
      chk("rst_ovr", o_overrun, 0);
      rst_n = 1'b1;
      drive_bit(1'b1);

      send_frame(8'hA5, 1'b1);
      drive_bit(1'b1);
      drain_and_count("a5");

      i_rx = 1'b0;
      repeat (5) tick();
      i_rx = 1'b1;
      repeat (2) tick();
      chk("glitch_busy_during", o_busy, 1);
      repeat (12) tick();
      chk("glitch_busy_after", o_busy, 0);
      chk("glitch_valid", o_valid, 0);
      drain_and_count("glitch");

      send_frame(8'h3C, 1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      chk("break_busy", o_busy, 0);
      send_frame(8'h81, 1'b1);
      drive_bit(1'b1);
      drain_and_count("ferr");

      i_ready = 1'b0;
      stall_mode = 1;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      drive_bit(1'b1);
      chk("hold_valid", o_valid, 1);
      chk("hold_data", o_data, 8'h11);
      i_ready = 1'b1;
      stall_mode = 0;
      m_full = 0;
      tick();
      tick();
      chk("pop_valid", o_valid, 0);
      chk("pop_data_kept", o_data, 8'h11);
      drain_and_count("overrun");

      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h55, 1'b1);
      drive_bit(1'b1);
      drain_and_count("b2b");

      rand_phase = 1;
      for (int n = 0; n < 40; n++) begin
         rb = 8'($urandom);
         ok = ($urandom_range(0, 7) != 0);
         send_frame(rb, ok);
         if (!ok) drive_bit(1'b1);
         repeat ($urandom_range(0, 2)) drive_bit(1'b1);
      end
      drive_bit(1'b1);
      rand_phase = 0;
      i_ready = 1'b1;
      drain_and_count("random");

      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b1);
      chk("mid_busy", o_busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      i_rx = 1'b1;
      repeat (8 * CPB) tick();
      chk("midrst_valid", o_valid, 0);
      chk("midrst_data", o_data, 0);
      chk("midrst_busy", o_busy, 0);
      drain_and_count("midrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
